// File: rtl/dram_dbg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_dbg_arbiter_if
// Brief    : Debug-monitor request/acknowledge bundle for dram_dbg_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_dbg_arbiter_if;
    logic        dbg_req;
    logic        dbg_we;
    logic [9:0]  dbg_adr;
    logic [31:0] dbg_wdata;
    logic [7:0]  dbg_len;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_busy;

    // Debug command decoder side
    modport master (
        output dbg_req, dbg_we, dbg_adr, dbg_wdata, dbg_len,
        input  dbg_ack, dbg_rdata, dbg_busy
    );

    // Arbiter side
    modport slave (
        input  dbg_req, dbg_we, dbg_adr, dbg_wdata, dbg_len,
        output dbg_ack, dbg_rdata, dbg_busy
    );
endinterface
`default_nettype wire

// File: rtl/dram_dbg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_dbg_arbiter
// Brief    : Lends the MA-stage data RAM port to the debug monitor once the
//            pipeline is stalled and no load/store occupies MA.
//            Optional burst transfers: define DBG_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dram_dbg_arbiter #(
    parameter int DRAIN_CYC = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dram_dbg_arbiter_if.slave dbg,
    output logic              cpu_stall_req,
    input  wire logic         stall,
    input  wire logic         cmd_ld_ma,
    input  wire logic         cmd_st_ma,
    output logic              d_read_sel,
    output logic [9:0]        d_ram_radr,
    input  wire logic [31:0]  d_ram_rdata,
    output logic              d_ram_wen,
    output logic [9:0]        d_ram_wadr,
    output logic [31:0]       d_ram_wdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STALL  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] c_drain_reload = 4'(DRAIN_CYC - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [9:0]  r_adr;
    logic [31:0] r_wdata;
    logic        w_ma_busy;

    assign w_ma_busy = cmd_ld_ma | cmd_st_ma;

`ifdef DBG_BURST_EN
    logic [7:0]  r_remain;
    logic        r_hold;
    logic        r_seen_low;
    logic        w_last;

    assign w_last = (r_remain == 8'd0);
`else
    logic        w_unused_len;

    assign w_unused_len = ^dbg.dbg_len;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_we          <= 1'b0;
            r_adr         <= 10'd0;
            r_wdata       <= 32'd0;
            dbg.dbg_ack   <= 1'b0;
            dbg.dbg_rdata <= 32'd0;
            dbg.dbg_busy  <= 1'b0;
            cpu_stall_req <= 1'b0;
            d_read_sel    <= 1'b0;
            d_ram_radr    <= 10'd0;
            d_ram_wen     <= 1'b0;
            d_ram_wadr    <= 10'd0;
            d_ram_wdata   <= 32'd0;
`ifdef DBG_BURST_EN
            r_remain      <= 8'd0;
            r_hold        <= 1'b0;
            r_seen_low    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dbg.dbg_req) begin
                        r_we          <= dbg.dbg_we;
                        r_adr         <= dbg.dbg_adr;
                        r_wdata       <= dbg.dbg_wdata;
                        dbg.dbg_busy  <= 1'b1;
                        cpu_stall_req <= 1'b1;
                        r_state       <= S_STALL;
`ifdef DBG_BURST_EN
                        r_remain      <= dbg.dbg_len;
                        r_hold        <= 1'b0;
                        r_seen_low    <= 1'b0;
`endif
                    end
                end

                S_STALL: begin
                    if (stall && !w_ma_busy) begin
                        r_cnt   <= c_drain_reload;
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Outputs are registered, so the override is raised on the
                    // edge that enters ACCESS.
                    if (!stall) begin
                        r_state <= S_STALL;
                    end else if (w_ma_busy) begin
                        r_cnt <= c_drain_reload;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                        if (r_we) begin
                            d_ram_wen   <= 1'b1;
                            d_ram_wadr  <= r_adr;
                            d_ram_wdata <= r_wdata;
                        end else begin
                            d_read_sel  <= 1'b1;
                            d_ram_radr  <= r_adr;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_ACCESS: begin
`ifdef DBG_BURST_EN
                    if (r_hold) begin
                        // Between burst words: wait for req to go low then high.
                        dbg.dbg_ack <= 1'b0;
                        if (!dbg.dbg_req) begin
                            r_seen_low <= 1'b1;
                        end else if (r_seen_low) begin
                            r_hold     <= 1'b0;
                            r_seen_low <= 1'b0;
                            if (r_we) begin
                                d_ram_wen   <= 1'b1;
                                d_ram_wadr  <= r_adr;
                                d_ram_wdata <= dbg.dbg_wdata;
                            end else begin
                                d_read_sel  <= 1'b1;
                                d_ram_radr  <= r_adr;
                            end
                        end
                    end else if (r_we) begin
                        d_ram_wen   <= 1'b0;
                        d_ram_wadr  <= 10'd0;
                        d_ram_wdata <= 32'd0;
                        dbg.dbg_ack <= 1'b1;
                        if (w_last) begin
                            cpu_stall_req <= 1'b0;
                            r_state       <= S_DONE;
                        end else begin
                            r_adr      <= r_adr + 10'd1;
                            r_remain   <= r_remain - 8'd1;
                            r_hold     <= 1'b1;
                            r_seen_low <= 1'b0;
                        end
                    end else begin
                        r_state <= S_RDATA;
                    end
`else
                    if (r_we) begin
                        d_ram_wen     <= 1'b0;
                        d_ram_wadr    <= 10'd0;
                        d_ram_wdata   <= 32'd0;
                        dbg.dbg_ack   <= 1'b1;
                        cpu_stall_req <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_state <= S_RDATA;
                    end
`endif
                end

                S_RDATA: begin
                    // RAM data for the address driven in ACCESS is valid now.
                    d_read_sel    <= 1'b0;
                    d_ram_radr    <= 10'd0;
                    dbg.dbg_rdata <= d_ram_rdata;
                    dbg.dbg_ack   <= 1'b1;
`ifdef DBG_BURST_EN
                    if (w_last) begin
                        cpu_stall_req <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_adr      <= r_adr + 10'd1;
                        r_remain   <= r_remain - 8'd1;
                        r_hold     <= 1'b1;
                        r_seen_low <= 1'b0;
                        r_state    <= S_ACCESS;
                    end
`else
                    cpu_stall_req <= 1'b0;
                    r_state       <= S_DONE;
`endif
                end

                S_DONE: begin
                    if (!dbg.dbg_req) begin
                        dbg.dbg_ack  <= 1'b0;
                        dbg.dbg_busy <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
